pcm_sample_pacer: RTL and testbench
===================================

# pcm_sample_pacer

Sample-rate pacing stage between a bytebeat generator and the PWM audio DAC. It pulls 8-bit PCM samples from the generator's valid/ready output stream into a 2-entry prefetch FIFO. It releases exactly one sample every DIV clocks, applying a selectable attenuation about mid-scale, and holds it steady for the PWM stage. It also counts underruns when the generator cannot keep up.

## Interface
- DIV, 6250, clocks per output sample (50 MHz / 8 kHz); legal range 2..65535
- DIV_W, 16, width of the internal tick counter; must hold DIV-1
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- run  in  1  1 = pacing enabled; 0 = counter held at 0, no pops
- vol  in  3  attenuation shift, 0 = unity, 7 = near-silent
- in_data  in  8  PCM sample from generator (unsigned, 0x80 = silence)
- in_vld  in  1  in_data valid
- in_rdy  out  1  FIFO can accept (not full)
- sample  out  8  held sample to PWM DAC
- sample_stb  out  1  one-cycle pulse; sample updated this cycle
- underrun  out  1  one-cycle pulse; tick occurred with FIFO empty
- underrun_cnt  out  8  saturating count of underruns

## Operation
- Reset values: sample=0x80, sample_stb=0, underrun=0, underrun_cnt=0, FIFO empty, tick counter=0. in_rdy is 1 in the first cycle after reset release.
- FIFO: 2 entries, first-in first-out. Push when in_vld & in_rdy. in_rdy = (count != 2), a registered-state function with no combinational path from in_vld.
- Tick counter: while run=1, counts 0..DIV-1 and wraps to 0. A tick is the cycle in which counter == DIV-1 and run=1. run=0 forces the counter to 0 on the next edge and suppresses ticks.
- On a tick with FIFO non-empty:
  - pop the head;
  - sample <= att(head, vol);
  - sample_stb <= 1.
- On a tick with FIFO empty:
  - sample holds its value;
  - underrun <= 1;
  - underrun_cnt increments, saturating at 255.
- Attenuation: s = head - 128, a 9-bit signed value. att = (s >>> vol) + 128, truncated to 8 bits. The shift is arithmetic. vol is sampled in the tick cycle. Examples: vol=1 maps 0xFF to 0xBF and 0x00 to 0x40; any vol maps 0x80 to 0x80.
- Simultaneous push and pop:
  - Count 1: both occur; count stays 1; order is preserved.
  - Count 2: push is blocked, since in_rdy=0 that cycle; pop occurs.
  - Count 0: push is accepted, but the pop sees the empty FIFO, so an underrun is raised. There is no bypass; the pushed sample is emitted at the next tick.
- in_vld=1 while in_rdy=0: no transfer. The generator holds its data; the block imposes no other requirement.
- Asynchronous reset mid-operation clears the FIFO, counter and all outputs immediately to their reset values. Pending samples are discarded.

## Timing
- All outputs are registered; sample and sample_stb change on the same clock edge.
- Tick period: exactly DIV clocks while run=1. The first tick is DIV clocks after run rises (counter 0 to DIV-1).
- Latency from push into an empty FIFO to sample update: at the next tick edge, at least 1 clock later.
- sample_stb and underrun are mutually exclusive. Each is high for exactly one cycle per tick and never high otherwise.
- Throughput: at most 1 sample per DIV clocks out. The input may burst 2 samples back-to-back after a pop.

## Test plan
- Reset and idle, DIV=4:
  - Assert rst_n=0 asynchronously mid-cycle -> sample=0x80, in_rdy=1 after release, all pulses 0.
  - run=0 for 20 clocks -> no stb, no underrun.
- Steady stream, DIV=4, vol=0:
  - Generator presents 0x10, 0x20, 0x30 with in_vld=1 -> in_rdy drops after 2 accepts.
  - sample_stb every 4 clocks; sample = 0x10, 0x20, 0x30 in order.
- Attenuation, DIV=4:
  - Push 0xFF with vol=1 -> sample=0xBF.
  - Push 0x00 with vol=7 -> sample=0x7F.
  - Push 0x80 with vol=3 -> sample=0x80.
- Underrun, DIV=4:
  - in_vld=0 with run=1 -> underrun pulses every 4 clocks, sample holds its last value.
  - After 300 ticks -> underrun_cnt=255, saturated.
- Push on the tick edge with FIFO empty: in_vld rises in the tick cycle with 0x55 -> underrun=1 that tick, then sample=0x55 with stb at the next tick.
- Reset mid-stream: FIFO full (0xAA, 0xBB), rst_n pulsed low for 1 clock between ticks -> FIFO empty, sample=0x80, 0xAA and 0xBB are never emitted.

Source files
------------

// File: rtl/pcm_sample_pacer.sv
// Paces 8-bit PCM samples from a valid/ready stream out at one sample every DIV clocks.
// A 2-entry prefetch FIFO absorbs jitter, the output applies volume attenuation about mid-scale,
// and underruns are counted with saturation.
module pcm_sample_pacer #(
    parameter int unsigned DIV   = 6250,
    parameter int unsigned DIV_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [2:0] vol,
    input  logic [7:0] in_data,
    input  logic       in_vld,
    output logic       in_rdy,
    output logic [7:0] sample,
    output logic       sample_stb,
    output logic       underrun,
    output logic [7:0] underrun_cnt
);

    localparam logic [DIV_W-1:0] LastCnt = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic [7:0]       sample_q, sample_d;
    logic             stb_q, stb_d;
    logic             und_q, und_d;
    logic [7:0]       und_cnt_q, und_cnt_d;

    logic             tick;
    logic             push;
    logic             pop;
    logic [7:0]       head;
    logic signed [8:0] centred;
    logic [7:0]       att;

    // in_rdy depends on registered occupancy only, so no path from in_vld
    assign in_rdy = (count_q != 2'd2);
    assign tick   = run && (cnt_q == LastCnt);
    assign push   = in_vld && in_rdy;
    // A push into an empty FIFO in the tick cycle cannot be popped the same cycle
    assign pop    = tick && (count_q != 2'd0);
    assign head   = mem_q[rd_ptr_q];

    assign centred = signed'({1'b0, head} - 9'd128);
    assign att     = 8'(centred >>> vol) + 8'd128;

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        sample_d  = sample_q;
        stb_d     = 1'b0;
        und_d     = 1'b0;
        und_cnt_d = und_cnt_q;
        if (tick) begin
            if (pop) begin
                sample_d = att;
                stb_d    = 1'b1;
            end else begin
                und_d = 1'b1;
                if (und_cnt_q != 8'hFF) begin
                    und_cnt_d = und_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q  <= 8'h80;
            stb_q     <= 1'b0;
            und_q     <= 1'b0;
            und_cnt_q <= '0;
        end else begin
            sample_q  <= sample_d;
            stb_q     <= stb_d;
            und_q     <= und_d;
            und_cnt_q <= und_cnt_d;
        end
    end

    assign sample       = sample_q;
    assign sample_stb   = stb_q;
    assign underrun     = und_q;
    assign underrun_cnt = und_cnt_q;

endmodule

// File: tb/tb_pcm_sample_pacer.sv
// Randomised and directed bench for pcm_sample_pacer with DIV=4, checked against a
// queue-based behavioural model evaluated once per clock.
module tb_pcm_sample_pacer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [2:0] vol = '0;
    logic [7:0] in_data = '0;
    logic       in_vld = 1'b0;
    logic       in_rdy;
    logic [7:0] sample;
    logic       sample_stb;
    logic       underrun;
    logic [7:0] underrun_cnt;

    pcm_sample_pacer #(
        .DIV   (DIV),
        .DIV_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .vol          (vol),
        .in_data      (in_data),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .sample       (sample),
        .sample_stb   (sample_stb),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    byte unsigned mq[$];
    int  run_cycles;
    int  e_sample;
    int  e_stb;
    int  e_und;
    int  e_cnt;
    bit  last_push;

    byte unsigned feed[$];
    byte unsigned seen[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int att(input int h, input int v);
        int s;
        s = h - 128;
        return ((s >>> v) + 128) & 255;
    endfunction

    task automatic model_reset();
        mq.delete();
        run_cycles = 0;
        e_sample   = 128;
        e_stb      = 0;
        e_und      = 0;
        e_cnt      = 0;
    endtask

    task automatic check_outputs();
        check("sample", 32'(sample), 32'(e_sample));
        check("sample_stb", 32'(sample_stb), 32'(e_stb));
        check("underrun", 32'(underrun), 32'(e_und));
        check("underrun_cnt", 32'(underrun_cnt), 32'(e_cnt));
        check("in_rdy", 32'(in_rdy), (mq.size() != 2) ? 32'd1 : 32'd0);
    endtask

    // One clock: advance the model on the edge, then compare just after it
    task automatic step();
        bit tick;
        @(posedge clk);
        tick      = run && ((run_cycles % DIV) == DIV - 1);
        last_push = in_vld && (mq.size() < 2);
        e_stb     = 0;
        e_und     = 0;
        if (tick) begin
            if (mq.size() > 0) begin
                e_sample = att(int'(mq.pop_front()), int'(vol));
                e_stb    = 1;
            end else begin
                e_und = 1;
                if (e_cnt < 255) e_cnt++;
            end
        end
        if (last_push) mq.push_back(in_data);
        run_cycles = run ? run_cycles + 1 : 0;
        #1;
        if (sample_stb) seen.push_back(sample);
        check_outputs();
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic feed_run(input int n);
        for (int i = 0; i < n; i++) begin
            if (feed.size() > 0) begin
                in_vld  = 1'b1;
                in_data = feed[0];
            end else begin
                in_vld = 1'b0;
            end
            step();
            if (last_push) void'(feed.pop_front());
        end
        in_vld = 1'b0;
    endtask

    task automatic att_case(input byte unsigned val, input int v, input int unsigned expv);
        bit got_stb;
        vol = 3'(v);
        feed.push_back(val);
        got_stb = 0;
        for (int i = 0; i < 20 && !got_stb; i++) begin
            feed_run(1);
            got_stb = sample_stb;
        end
        check("att_stb_seen", 32'(got_stb), 32'd1);
        check("att_value", 32'(sample), 32'(expv));
    endtask

    initial begin
        int stb_seen;
        bit found;
        model_reset();
        last_push = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset and idle
        pulse_reset();
        run = 1'b0;
        repeat (20) step();

        // Steady stream
        run = 1'b1;
        vol = 3'd0;
        seen.delete();
        feed = '{8'h10, 8'h20, 8'h30};
        feed_run(16);
        check("steady_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("steady_0", 32'(seen[0]), 32'h10);
            check("steady_1", 32'(seen[1]), 32'h20);
            check("steady_2", 32'(seen[2]), 32'h30);
        end

        // Attenuation
        att_case(8'hFF, 1, 32'hBF);
        att_case(8'h00, 7, 32'h7F);
        att_case(8'h80, 3, 32'h80);
        att_case(8'h00, 1, 32'h40);

        // Underrun saturation
        in_vld = 1'b0;
        repeat (300 * DIV) step();
        check("und_saturated", 32'(underrun_cnt), 32'd255);

        // Push in the tick cycle with the FIFO empty
        pulse_reset();
        run = 1'b1;
        vol = 3'd0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (((run_cycles % DIV) == DIV - 1) && mq.size() == 0) found = 1;
            else step();
        end
        check("edge_found", 32'(found), 32'd1);
        in_vld  = 1'b1;
        in_data = 8'h55;
        step();
        in_vld = 1'b0;
        check("edge_underrun", 32'(underrun), 32'd1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = sample_stb;
        end
        check("edge_stb", 32'(found), 32'd1);
        check("edge_sample", 32'(sample), 32'h55);

        // Reset mid-stream discards queued samples
        run = 1'b0;
        feed = '{8'hAA, 8'hBB};
        feed_run(3);
        check("full_before_reset", 32'(in_rdy), 32'd0);
        run = 1'b1;
        step();
        pulse_reset();
        seen.delete();
        feed.delete();
        in_vld = 1'b0;
        repeat (4 * DIV) step();
        stb_seen = seen.size();
        check("no_stale_samples", 32'(stb_seen), 32'd0);
        check("stale_sample_value", 32'(sample), 32'h80);

        // Randomised traffic
        last_push = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!in_vld || last_push) begin
                in_vld  = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
                in_data = 8'($urandom);
            end
            run = ($urandom_range(0, 15) != 0);
            vol = 3'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
                last_push = 0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
